// File: rtl/meter_seg_display_if.sv
// Display-side signal bundle for the parking-meter seven-segment display.
// master: remaining-time producer / board observer; slave: meter_seg_display.
interface meter_seg_display_if;
    logic [13:0] time_in;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic [1:0]  mode;

    modport master (output time_in, input seg, an, dp, mode);
    modport slave  (input time_in, output seg, an, dp, mode);
endinterface

// File: rtl/meter_seg_display.sv
// Remaining-time to 4-digit multiplexed seven-segment display with meter flash policy.
// Optional LEADING_ZERO_BLANK_EN suppresses digits above the most significant nonzero one.
module meter_seg_display #(
    parameter int DIGIT_DIV = 100000,
    parameter int QTR_SEC   = 25000000
) (
    input logic                clk,
    input logic                rst_n,
    meter_seg_display_if.slave bus
);
    localparam int DivW = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
    localparam int QtrW = (QTR_SEC > 1) ? $clog2(QTR_SEC) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} convState_t;

    function automatic logic [13:0] satTime(input logic [13:0] v);
        return (v > 14'd9999) ? 14'd9999 : v;
    endfunction

    // One double-dabble iteration: correct each nibble, then shift in the next binary bit.
    function automatic logic [15:0] dabbleStep(input logic [15:0] bcd, input logic msb);
        logic [15:0] adj;
        for (int i = 0; i < 4; i++) begin
            adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        end
        return {adj[14:0], msb};
    endfunction

    function automatic logic [6:0] segPattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    convState_t       state, stateNext;
    logic [13:0]      timeSat, binReg, capVal, lastVal;
    logic [15:0]      bcdReg, digits;
    logic [3:0]       bitCnt;
    logic             firstConv;

    logic [1:0]       modeNext, modeReg, phase;
    logic [QtrW-1:0]  qtrCnt;
    logic [DivW-1:0]  scanCnt;
    logic [1:0]       scanIdx;

    logic             blank;
    logic [3:0]       slotOn, curDigit, anNext, anReg;
    logic [6:0]       segNext, segReg;
    logic             dpReg;

    assign timeSat = satTime(bus.time_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (firstConv || (timeSat != lastVal)) stateNext = LOAD;
            LOAD:    stateNext = SHIFT;
            SHIFT:   if (bitCnt == 4'd13) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Digits and lastVal change together in DONE, so the display never shows a partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            binReg    <= '0;
            capVal    <= '0;
            bcdReg    <= '0;
            bitCnt    <= '0;
            digits    <= '0;
            lastVal   <= '0;
            firstConv <= 1'b1;
        end else begin
            case (state)
                IDLE: firstConv <= 1'b0;
                LOAD: begin
                    binReg <= timeSat;
                    capVal <= timeSat;
                    bcdReg <= '0;
                    bitCnt <= '0;
                end
                SHIFT: begin
                    bcdReg <= dabbleStep(bcdReg, binReg[13]);
                    binReg <= {binReg[12:0], 1'b0};
                    bitCnt <= bitCnt + 4'd1;
                end
                DONE: begin
                    digits  <= bcdReg;
                    lastVal <= capVal;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        modeNext = 2'd2;
        if (lastVal == 14'd0)        modeNext = 2'd0;
        else if (lastVal < 14'd200)  modeNext = 2'd1;
    end

    // A mode change restarts the blink so the new mode begins in its lit phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modeReg <= 2'd0;
            qtrCnt  <= '0;
            phase   <= 2'd0;
        end else if (modeNext != modeReg) begin
            modeReg <= modeNext;
            qtrCnt  <= '0;
            phase   <= 2'd0;
        end else if (qtrCnt == QtrW'(QTR_SEC - 1)) begin
            qtrCnt  <= '0;
            phase   <= phase + 2'd1;
        end else begin
            qtrCnt  <= qtrCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scanCnt <= '0;
            scanIdx <= 2'd0;
        end else if (scanCnt == DivW'(DIGIT_DIV - 1)) begin
            scanCnt <= '0;
            scanIdx <= scanIdx + 2'd1;
        end else begin
            scanCnt <= scanCnt + 1'b1;
        end
    end

    always_comb begin
        blank    = ((modeReg == 2'd0) && phase[0]) || ((modeReg == 2'd1) && phase[1]);
        curDigit = digits[{scanIdx, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        slotOn[3] = (digits[15:12] != 4'd0);
        slotOn[2] = slotOn[3] || (digits[11:8] != 4'd0);
        slotOn[1] = slotOn[2] || (digits[7:4] != 4'd0);
        slotOn[0] = 1'b1;
`else
        slotOn    = 4'hF;
`endif
        anNext  = 4'hF;
        segNext = 7'h7F;
        if (!blank && slotOn[scanIdx]) begin
            anNext  = ~(4'b0001 << scanIdx);
            segNext = segPattern(curDigit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segReg <= 7'h7F;
            anReg  <= 4'hF;
            dpReg  <= 1'b1;
        end else begin
            segReg <= segNext;
            anReg  <= anNext;
            dpReg  <= 1'b1;
        end
    end

    assign bus.seg  = segReg;
    assign bus.an   = anReg;
    assign bus.dp   = dpReg;
    assign bus.mode = modeReg;
endmodule

// File: tb/tb_meter_seg_display.sv
// Bench for meter_seg_display: cycle model of display behaviour plus directed literal checks.
module tb_meter_seg_display;
    localparam int DIGIT_DIV = 4;
    localparam int QTR_SEC   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    meter_seg_display_if bus();

    meter_seg_display #(.DIGIT_DIV(DIGIT_DIV), .QTR_SEC(QTR_SEC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit checkOn     = 1'b0;

    logic [6:0] segTab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pow10(input int k);
        case (k)
            0: return 1;
            1: return 10;
            2: return 100;
            default: return 1000;
        endcase
    endfunction

    function automatic int modeOf(input int v);
        if (v == 0) return 0;
        if (v < 200) return 1;
        return 2;
    endfunction

    // Model state: edges since reset / since mode change, conversion progress, shown value.
    int scanEdges, sinceMode, convT, capVal, dispVal, modeM;
    bit firstPend;
    logic [6:0] expSeg;
    logic [3:0] expAn;
    logic [1:0] expMode;

    task automatic modelReset();
        scanEdges = 0; sinceMode = 0; convT = 0; capVal = 0; dispVal = 0;
        modeM = 0; firstPend = 1'b1;
        expSeg = 7'h7F; expAn = 4'hF; expMode = 2'd0;
    endtask

    task automatic modelStep(input int tin);
        int slot, phase, dig, newMode;
        bit shown;
        phase = (sinceMode / QTR_SEC) % 4;
        slot  = (scanEdges / DIGIT_DIV) % 4;
        shown = !((modeM == 0 && (phase % 2) == 1) || (modeM == 1 && phase >= 2));
`ifdef LEADING_ZERO_BLANK_EN
        if (slot != 0 && dispVal < pow10(slot)) shown = 1'b0;
`endif
        dig    = (dispVal / pow10(slot)) % 10;
        expAn  = shown ? ~(4'b0001 << slot) : 4'hF;
        expSeg = shown ? segTab[dig] : 7'h7F;
        newMode = modeOf(dispVal);
        if (newMode != modeM) begin
            modeM = newMode;
            sinceMode = 0;
        end else begin
            sinceMode++;
        end
        expMode = 2'(modeM);
        scanEdges++;
        // Conversion: detect, capture one edge later, 14 shift edges, then publish.
        if (convT == 0) begin
            if (firstPend || tin != dispVal) begin
                convT = 1;
                firstPend = 1'b0;
            end
        end else if (convT == 1) begin
            capVal = tin;
            convT = 2;
        end else if (convT < 16) begin
            convT++;
        end else begin
            dispVal = capVal;
            convT = 0;
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep((int'(bus.time_in) > 9999) ? 9999 : int'(bus.time_in));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checkOn) begin
                check("seg",  16'(bus.seg),  16'(expSeg));
                check("an",   16'(bus.an),   16'(expAn));
                check("mode", 16'(bus.mode), 16'(expMode));
                check("dp",   16'(bus.dp),   16'd1);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int lit, thou, blanks, seg40;
    int rapidVals [5] = '{3000, 45, 777, 6000, 1234};

    initial begin
        bus.time_in = 14'd0;
        #1 rst_n = 1'b0;
        #2 checkOn = 1'b1;
        #1;
        check("rst_seg",  16'(bus.seg),  16'h7F);
        check("rst_an",   16'(bus.an),   16'hF);
        check("rst_mode", 16'(bus.mode), 16'd0);
        check("rst_dp",   16'(bus.dp),   16'd1);
        cycles(2);
        rst_n = 1'b1;

        // Zero: fast flash, every lit cycle shows "0".
        cycles(30);
        lit = 0; seg40 = 0;
        repeat (64) begin
            @(negedge clk); #1;
            if (bus.an != 4'hF) lit++;
            if (bus.an != 4'hF && bus.seg == 7'h40) seg40++;
        end
`ifdef LEADING_ZERO_BLANK_EN
        check("lit_zero", 16'(lit), 16'd16);
`else
        check("lit_zero", 16'(lit), 16'd32);
`endif
        check("seg40_zero", 16'(seg40), 16'(lit));
        check("mode_zero", 16'(bus.mode), 16'd0);

        // 205: solid, ones slot shows 5.
        @(negedge clk);
        bus.time_in = 14'd205;
        cycles(20);
        #1 check("mode_205", 16'(bus.mode), 16'd2);
        blanks = 0;
        repeat (16) begin
            @(negedge clk); #1;
            if (bus.an == 4'hF) blanks++;
            if (bus.an == 4'hE) check("ones_205", 16'(bus.seg), 16'h12);
        end
`ifdef LEADING_ZERO_BLANK_EN
        check("blanks_205", 16'(blanks), 16'd4);
`else
        check("blanks_205", 16'(blanks), 16'd0);
`endif

        // 150: slow flash, 16 lit then 16 dark after the mode switch.
        @(negedge clk);
        bus.time_in = 14'd150;
        for (int i = 0; i < 40 && bus.mode != 2'd1; i++) begin
            @(negedge clk); #1;
        end
        check("mode_150", 16'(bus.mode), 16'd1);
        lit = 0; thou = 0;
        repeat (16) begin
            @(negedge clk); #1;
            if (bus.an != 4'hF) lit++;
            if (bus.an == 4'h7) begin
                thou++;
                check("thou_150", 16'(bus.seg), 16'h40);
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        check("lit_150",  16'(lit),  16'd12);
        check("thouN_150", 16'(thou), 16'd0);
`else
        check("lit_150",  16'(lit),  16'd16);
        check("thouN_150", 16'(thou), 16'd4);
`endif
        lit = 0;
        repeat (16) begin
            @(negedge clk); #1;
            if (bus.an != 4'hF) lit++;
        end
        check("dark_150", 16'(lit), 16'd0);

        // Out-of-range input saturates to 9999.
        @(negedge clk);
        bus.time_in = 14'h3FFF;
        cycles(22);
        #1 check("mode_9999", 16'(bus.mode), 16'd2);
        repeat (16) begin
            @(negedge clk); #1;
            check("seg_9999", 16'(bus.seg), 16'h10);
            check("an_lit_9999", 16'(bus.an == 4'hF), 16'd0);
        end

        // Rapid changes during conversion; model catches any torn digits.
        foreach (rapidVals[i]) begin
            @(negedge clk);
            bus.time_in = 14'(rapidVals[i]);
            cycles(4);
        end
        cycles(34);
        repeat (16) begin
            @(negedge clk); #1;
            if (bus.an == 4'hE) check("ones_1234", 16'(bus.seg), 16'h19);
            if (bus.an == 4'h7) check("thou_1234", 16'(bus.seg), 16'h79);
        end

        // Asynchronous reset in the middle of a conversion and scan.
        @(negedge clk);
        bus.time_in = 14'd4321;
        cycles(6);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_seg",  16'(bus.seg),  16'h7F);
        check("mrst_an",   16'(bus.an),   16'hF);
        check("mrst_mode", 16'(bus.mode), 16'd0);
        check("mrst_dp",   16'(bus.dp),   16'd1);
        cycles(2);
        rst_n = 1'b1;
        cycles(25);
        #1 check("mode_4321", 16'(bus.mode), 16'd2);
        repeat (16) begin
            @(negedge clk); #1;
            if (bus.an == 4'hE) check("ones_4321", 16'(bus.seg), 16'h79);
            if (bus.an == 4'h7) check("thou_4321", 16'(bus.seg), 16'h19);
        end

        cycles(2);
        checkOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
